// File: rtl/dmem_line_ctrl.sv
// Line-to-word backing-memory controller: splits 128-bit D-cache line requests into four 32-bit SRAM beats.
// Optional address range checking is compiled in with `define DMEM_RANGE_CHECK_EN.
module dmem_line_ctrl #(
  parameter int          SRAM_AW   = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cs_i,
  input  logic                 we_i,
  input  logic [31:0]          addr_i,
  input  logic [127:0]         wdata_i,
  output logic [127:0]         rdata_o,
  output logic                 rvalid_o,
  output logic                 busy_o,
  output logic                 err_o,
  output logic [SRAM_AW-1:0]   sram_addr_o,
  output logic [31:0]          sram_wdata_o,
  output logic                 sram_we_o,
  output logic                 sram_re_o,
  input  logic [31:0]          sram_rdata_i
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    DRAIN = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           beat_q, beat_d;
  logic [SRAM_AW-3:0]   line_q;
  logic [127:0]         wdata_q;
  logic [95:0]          rbuf_q;
  logic [31:0]          off;
  logic [SRAM_AW-3:0]   req_line;
  logic                 req_err;
  logic                 accept;
  logic                 unused_off;

  assign off        = addr_i - BASE_ADDR;
  assign req_line   = off[SRAM_AW+1:4];
  assign accept     = (state_q == IDLE) && cs_i;
  assign unused_off = ^{off[3:0], off[31:SRAM_AW+2]};

`ifdef DMEM_RANGE_CHECK_EN
  logic err_q;

  function automatic logic out_of_range(input logic [31:0] o);
    return (o >> (SRAM_AW + 2)) != 32'd0;
  endfunction

  assign req_err = out_of_range(off);
  assign err_o   = (state_q == RESP) && err_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= req_err;
    end
  end
`else
  assign req_err = 1'b0;
  assign err_o   = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        beat_d = 2'd0;
        if (cs_i) begin
          if (req_err)   state_d = RESP;
          else if (we_i) state_d = WRITE;
          else           state_d = READ;
        end
      end
      READ: begin
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) state_d = DRAIN;
      end
      DRAIN: state_d = RESP;
      WRITE: begin
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the registered state so every strobe is glitch-free of inputs
  always_comb begin
    busy_o       = (state_q != IDLE);
    rvalid_o     = (state_q == RESP);
    sram_re_o    = (state_q == READ);
    sram_we_o    = (state_q == WRITE);
    sram_addr_o  = '0;
    sram_wdata_o = 32'd0;
    if (state_q == READ || state_q == WRITE) begin
      sram_addr_o = {line_q, beat_q};
    end
    if (state_q == WRITE) begin
      sram_wdata_o = wdata_q[{beat_q, 5'd0} +: 32];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      beat_q  <= 2'd0;
      rdata_o <= 128'd0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (state_q == DRAIN) begin
        rdata_o <= {sram_rdata_i, rbuf_q};
      end else if (accept && req_err && !we_i) begin
        rdata_o <= 128'd0;
      end
    end
  end

  // Request latch and read-beat assembly; SRAM data lags the strobe by one cycle
  always_ff @(posedge clk_i) begin
    if (accept) begin
      line_q  <= req_line;
      wdata_q <= wdata_i;
    end
    if (state_q == READ) begin
      case (beat_q)
        2'd1:    rbuf_q[31:0]  <= sram_rdata_i;
        2'd2:    rbuf_q[63:32] <= sram_rdata_i;
        2'd3:    rbuf_q[95:64] <= sram_rdata_i;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_line_ctrl.sv
// Scoreboard bench for dmem_line_ctrl with a behavioural 1-cycle-latency word SRAM.
module tb_dmem_line_ctrl;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          cs_i = 1'b0;
  logic          we_i = 1'b0;
  logic [31:0]   addr_i = 32'd0;
  logic [127:0]  wdata_i = 128'd0;
  logic [127:0]  rdata_o;
  logic          rvalid_o, busy_o, err_o;
  logic [AW-1:0] sram_addr_o;
  logic [31:0]   sram_wdata_o;
  logic          sram_we_o, sram_re_o;
  logic [31:0]   sram_rdata_i;

  logic [31:0]   mem     [0:1023];
  logic [31:0]   ref_mem [0:1023];
  logic [127:0]  exp_q[$];
  logic [127:0]  last_read;
  int            cyc = 0;
  int            n_checks = 0;
  int            n_fails = 0;
  int            last_rv_cyc = 0;

  dmem_line_ctrl #(.SRAM_AW(AW), .BASE_ADDR(32'h0000_0000)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .cs_i(cs_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .rdata_o(rdata_o), .rvalid_o(rvalid_o), .busy_o(busy_o),
    .err_o(err_o), .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o),
    .sram_we_o(sram_we_o), .sram_re_o(sram_re_o), .sram_rdata_i(sram_rdata_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sram_we_o) mem[sram_addr_o] <= sram_wdata_o;
    if (sram_re_o) sram_rdata_i <= mem[sram_addr_o];
  end

  // Issue one transaction at a negedge in IDLE; returns at the negedge of the following IDLE cycle.
  task automatic txn(input bit we, input logic [31:0] addr, input logic [127:0] wd, input int drop_at);
    logic [31:0]  off;
    logic [9:0]   w0;
    logic [127:0] exp_line, got;
    bit           err, seen;
    int           lat, exp_lat, n_strobe;
    off = addr - 32'h0000_0000;
    err = 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
    err = (off >= 32'h0000_1000);
`endif
    w0 = {off[11:4], 2'b00};
    if (err) begin
      exp_line = we ? last_read : 128'd0;
      exp_lat  = 1;
    end else if (we) begin
      for (int k = 0; k < 4; k++) ref_mem[w0 + 10'(k)] = wd[32*k +: 32];
      exp_line = last_read;
      exp_lat  = 5;
    end else begin
      for (int k = 0; k < 4; k++) exp_line[32*k +: 32] = ref_mem[w0 + 10'(k)];
      exp_lat = 6;
    end
    if (!we) last_read = exp_line;
    exp_q.push_back(exp_line);
    cs_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wd;
    @(posedge clk);
    lat = 0; n_strobe = 0; seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == drop_at) cs_i = 1'b0;
      n_checks++;
      if (sram_re_o && sram_we_o) begin
        n_fails++;
        $display("FAIL strobe_excl addr=%h: re=%b we=%b both high", addr, sram_re_o, sram_we_o);
      end
      if (sram_re_o || sram_we_o) n_strobe++;
      if (rvalid_o) seen = 1'b1;
    end
    cs_i = 1'b0;
    got = exp_q.pop_front();
    n_checks++;
    if (!seen) begin n_fails++; $display("FAIL rvalid_timeout addr=%h: no rvalid in %0d cycles", addr, lat); end
    n_checks++;
    if (lat !== exp_lat) begin n_fails++; $display("FAIL latency addr=%h we=%b: got %0d expected %0d", addr, we, lat, exp_lat); end
    n_checks++;
    if (rdata_o !== got) begin n_fails++; $display("FAIL rdata addr=%h we=%b: got %h expected %h", addr, we, rdata_o, got); end
    n_checks++;
    if (err_o !== err) begin n_fails++; $display("FAIL err addr=%h: got %b expected %b", addr, err_o, err); end
    n_checks++;
    if (n_strobe !== (err ? 0 : 4)) begin n_fails++; $display("FAIL strobe_count addr=%h: got %0d expected %0d", addr, n_strobe, err ? 0 : 4); end
    last_rv_cyc = cyc;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; cs_i = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (rvalid_o !== 1'b0) begin n_fails++; $display("FAIL reset_rvalid: got %b expected 0", rvalid_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fails++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    n_checks++; if (err_o !== 1'b0) begin n_fails++; $display("FAIL reset_err: got %b expected 0", err_o); end
    n_checks++; if (rdata_o !== 128'd0) begin n_fails++; $display("FAIL reset_rdata: got %h expected 0", rdata_o); end
    n_checks++; if (sram_re_o !== 1'b0) begin n_fails++; $display("FAIL reset_re: got %b expected 0", sram_re_o); end
    n_checks++; if (sram_we_o !== 1'b0) begin n_fails++; $display("FAIL reset_we: got %b expected 0", sram_we_o); end
    n_checks++; if (sram_addr_o !== '0) begin n_fails++; $display("FAIL reset_addr: got %h expected 0", sram_addr_o); end
    n_checks++; if (sram_wdata_o !== 32'd0) begin n_fails++; $display("FAIL reset_wdata: got %h expected 0", sram_wdata_o); end
    last_read = 128'd0;
    rst_ni = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    logic [31:0] words [4];
    words = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    txn(1'b1, 32'h40, 128'h0F0E0D0C_0B0A0908_07060504_03020100, 0);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (mem[10'h10 + 10'(k)] !== words[k]) begin
        n_fails++; $display("FAIL wr_word%0d: got %h expected %h", k, mem[10'h10 + 10'(k)], words[k]);
      end
    end
    txn(1'b0, 32'h4C, 128'd0, 0);
    n_checks++;
    if (rdata_o !== 128'h0F0E0D0C_0B0A0908_07060504_03020100) begin
      n_fails++; $display("FAIL rd_line_hold: got %h expected 0f0e0d0c0b0a09080706050403020100", rdata_o);
    end
  endtask

  task automatic test_back_to_back();
    int c1;
    txn(1'b1, 32'h10, {$urandom, $urandom, $urandom, $urandom}, 0);
    txn(1'b1, 32'h00, {$urandom, $urandom, $urandom, $urandom}, 0);
    txn(1'b0, 32'h10, 128'd0, 0);
    c1 = last_rv_cyc;
    n_checks++;
    if (busy_o !== 1'b0) begin n_fails++; $display("FAIL b2b_busy_gap: got %b expected 0", busy_o); end
    txn(1'b0, 32'h00, 128'd0, 0);
    n_checks++;
    if (last_rv_cyc - c1 !== 7) begin n_fails++; $display("FAIL b2b_spacing: got %0d expected 7", last_rv_cyc - c1); end
  endtask

  task automatic test_reset_mid_read();
    int n_rv;
    cs_i = 1'b1; we_i = 1'b0; addr_i = 32'h40;
    @(posedge clk);
    repeat (3) @(negedge clk);
    rst_ni = 1'b0; cs_i = 1'b0;
    @(negedge clk);
    n_checks++; if (busy_o !== 1'b0) begin n_fails++; $display("FAIL midrst_busy: got %b expected 0", busy_o); end
    n_checks++; if (rvalid_o !== 1'b0) begin n_fails++; $display("FAIL midrst_rvalid: got %b expected 0", rvalid_o); end
    n_checks++; if (sram_re_o !== 1'b0) begin n_fails++; $display("FAIL midrst_re: got %b expected 0", sram_re_o); end
    n_checks++; if (sram_addr_o !== '0) begin n_fails++; $display("FAIL midrst_addr: got %h expected 0", sram_addr_o); end
    n_checks++; if (rdata_o !== 128'd0) begin n_fails++; $display("FAIL midrst_rdata: got %h expected 0", rdata_o); end
    last_read = 128'd0;
    rst_ni = 1'b1;
    n_rv = 0;
    repeat (8) begin @(negedge clk); if (rvalid_o) n_rv++; end
    n_checks++; if (n_rv !== 0) begin n_fails++; $display("FAIL midrst_stray_rvalid: got %0d expected 0", n_rv); end
    txn(1'b0, 32'h40, 128'd0, 0);
  endtask

  task automatic test_cs_drop();
    logic [127:0] wd;
    wd = {$urandom, $urandom, $urandom, $urandom};
    txn(1'b1, 32'h80, wd, 2);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (mem[10'h20 + 10'(k)] !== wd[32*k +: 32]) begin
        n_fails++; $display("FAIL csdrop_word%0d: got %h expected %h", k, mem[10'h20 + 10'(k)], wd[32*k +: 32]);
      end
    end
    txn(1'b0, 32'h80, 128'd0, 0);
  endtask

  task automatic test_range();
    txn(1'b0, 32'h1000, 128'd0, 0);
    txn(1'b1, 32'h2000, {$urandom, $urandom, $urandom, $urandom}, 0);
    txn(1'b0, 32'h0, 128'd0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++)
      txn(1'b1, 32'h100 + 32'(16 * i), {$urandom, $urandom, $urandom, $urandom}, 0);
    for (int i = 0; i < 200; i++)
      txn(1'($urandom_range(0, 1)), 32'h100 + 32'(16 * $urandom_range(0, 15)) + 32'($urandom_range(0, 15)),
          {$urandom, $urandom, $urandom, $urandom}, 0);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_write_read();
    test_back_to_back();
    test_reset_mid_read();
    test_cs_drop();
    test_range();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
